// File: rtl/move_sequencer.sv
// Input stage for the tic-tac-toe game-state block: debounces buttons, steers a tile cursor
// and issues move requests, alternating the player once the board confirms each move.
module move_sequencer #(
   parameter int unsigned DB_CYCLES    = 16,
   parameter int unsigned WAIT_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_place,
   input  logic [8:0] X_state,
   input  logic [8:0] O_state,
   input  logic [2:0] GameStatus,
   output logic       move,
   output logic       player,
   output logic [3:0] nextMove,
   output logic [3:0] cursor,
   output logic       busy,
   output logic       reject
);

   localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
   localparam int unsigned WtW = $clog2(WAIT_TIMEOUT + 1);
   localparam int unsigned NumBtn = 3;

   typedef enum logic [1:0] {
      StSelect,
      StIssue,
      StWait,
      StDone
   } state_e;

   // ---------------------------------------------------------------------------------------
   // Button conditioning: index 0 = next, 1 = prev, 2 = place
   // ---------------------------------------------------------------------------------------
   logic [NumBtn-1:0] btn_raw;
   logic [NumBtn-1:0] sync1_q, sync2_q;
   logic [NumBtn-1:0] db_q, db_d;
   logic [NumBtn-1:0] press_q, press_d;
   logic [DbW-1:0]    db_cnt_q [NumBtn];
   logic [DbW-1:0]    db_cnt_d [NumBtn];

   assign btn_raw = {btn_place, btn_prev, btn_next};

   always_comb begin
      db_d    = db_q;
      press_d = '0;
      for (int i = 0; i < NumBtn; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
               db_d[i]    = sync2_q[i];
               press_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         press_q <= '0;
         for (int i = 0; i < NumBtn; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         press_q <= press_d;
         for (int i = 0; i < NumBtn; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   logic press_next, press_prev, press_place;

   assign press_next  = press_q[0];
   assign press_prev  = press_q[1];
   assign press_place = press_q[2];

   // ---------------------------------------------------------------------------------------
   // Board occupancy: tile k lives at bit (9-k)
   // ---------------------------------------------------------------------------------------
   logic [8:0] occ;

   assign occ = X_state | O_state;

   function automatic logic tile_occ(input logic [8:0] board, input logic [3:0] k);
      logic res;
      res = 1'b0;
      if (k >= 4'd1 && k <= 4'd9) begin
         res = board[4'd9 - k];
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------------------
   // Move sequencing FSM
   // ---------------------------------------------------------------------------------------
   state_e         state_q, state_d;
   logic [3:0]     cursor_q, cursor_d;
   logic [3:0]     next_move_q, next_move_d;
   logic           player_q, player_d;
   logic [WtW-1:0] wait_cnt_q, wait_cnt_d;
   logic           reject_q, reject_d;
   logic           game_over;

   assign game_over = (GameStatus == 3'd1) || (GameStatus == 3'd2) || (GameStatus == 3'd3);

   always_comb begin
      state_d     = state_q;
      cursor_d    = cursor_q;
      next_move_d = next_move_q;
      player_d    = player_q;
      wait_cnt_d  = wait_cnt_q;
      reject_d    = 1'b0;

      unique case (state_q)
         StSelect: begin
            if (game_over) begin
               state_d = StDone;
            end else if (press_place) begin
               if (tile_occ(occ, cursor_q)) begin
                  reject_d = 1'b1;
               end else begin
                  next_move_d = cursor_q;
                  state_d     = StIssue;
               end
            end else if (press_next && !press_prev) begin
               cursor_d = (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
            end else if (press_prev && !press_next) begin
               cursor_d = (cursor_q == 4'd1) ? 4'd9 : cursor_q - 4'd1;
            end
         end

         StIssue: begin
            wait_cnt_d = '0;
            state_d    = StWait;
         end

         // Presses arriving here are dropped on purpose; only the board answer matters.
         StWait: begin
            if (tile_occ(occ, next_move_q)) begin
               player_d   = ~player_q;
               wait_cnt_d = '0;
               state_d    = StSelect;
            end else if (wait_cnt_q == WtW'(WAIT_TIMEOUT - 1)) begin
               reject_d   = 1'b1;
               wait_cnt_d = '0;
               state_d    = StSelect;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         StDone: begin
            if (GameStatus == 3'd0 && occ == 9'd0) begin
               player_d = 1'b1;
               cursor_d = 4'd5;
               state_d  = StSelect;
            end
         end

         default: begin
            state_d = StSelect;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StSelect;
         cursor_q    <= 4'd5;
         next_move_q <= 4'd0;
         player_q    <= 1'b1;
         wait_cnt_q  <= '0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         next_move_q <= next_move_d;
         player_q    <= player_d;
         wait_cnt_q  <= wait_cnt_d;
         reject_q    <= reject_d;
      end
   end

   assign move     = (state_q == StIssue);
   assign busy     = (state_q == StIssue) || (state_q == StWait);
   assign reject   = reject_q;
   assign player   = player_q;
   assign nextMove = next_move_q;
   assign cursor   = cursor_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: expected move/reject events are queued by the stimulus
// and matched by a separate monitor; cursor, busy and player are checked inline.
module tb_move_sequencer;

   logic       clk;
   logic       rst;
   logic [2:0] btn;
   logic [8:0] X_state;
   logic [8:0] O_state;
   logic [2:0] GameStatus;
   logic       move;
   logic       player;
   logic [3:0] nextMove;
   logic [3:0] cursor;
   logic       busy;
   logic       reject;

   move_sequencer #(
      .DB_CYCLES   (4),
      .WAIT_TIMEOUT(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_next  (btn[0]),
      .btn_prev  (btn[1]),
      .btn_place (btn[2]),
      .X_state   (X_state),
      .O_state   (O_state),
      .GameStatus(GameStatus),
      .move      (move),
      .player    (player),
      .nextMove  (nextMove),
      .cursor    (cursor),
      .busy      (busy),
      .reject    (reject)
   );

   typedef struct packed {
      bit       is_move;
      bit [3:0] tile;
      bit       plyr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input bit is_move, input bit [3:0] tile, input bit plyr);
      exp_t e;
      e.is_move = is_move;
      e.tile    = tile;
      e.plyr    = plyr;
      return e;
   endfunction

   // Scoreboard monitor: every move or reject pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && (move || reject)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event(move,reject)", {30'd0, move, reject}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_is_move", move, mon_e.is_move);
            check("event_is_reject", reject, !mon_e.is_move);
            if (mon_e.is_move) check("move_tile", nextMove, mon_e.tile);
            check("event_player", player, mon_e.plyr);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press and release one button long enough for both edges to debounce.
   task automatic tap(input int b);
      btn[b] = 1'b1;
      step(10);
      btn[b] = 1'b0;
      step(10);
   endtask

   task automatic wait_move();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (move) seen = 1'b1;
      end
      check("move_seen", seen, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cursor"}, cursor, 5);
      check({tag, "_nextMove"}, nextMove, 0);
      check({tag, "_player"}, player, 1);
      check({tag, "_move"}, move, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_reject"}, reject, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b0;
      btn        = 3'b000;
      X_state    = 9'd0;
      O_state    = 9'd0;
      GameStatus = 3'd0;
      step(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      step(2);

      // 1: cursor stepping and wrap-around
      tap(0); check("t1_next1", cursor, 6);
      tap(0); check("t1_next2", cursor, 7);
      tap(0); check("t1_next3", cursor, 8);
      tap(1); check("t1_prev", cursor, 7);
      tap(0); tap(0); check("t1_at9", cursor, 9);
      tap(0); check("t1_wrap_next", cursor, 1);
      tap(1); check("t1_wrap_prev", cursor, 9);

      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(2);

      // 2: successful placement, board answers two cycles after the request
      exp_q.push_back(mk(1'b1, 4'd5, 1'b1));
      btn[2] = 1'b1;
      wait_move();
      check("t2_busy_issue", busy, 1);
      step(1);
      check("t2_busy_wait1", busy, 1);
      check("t2_move_once", move, 0);
      check("t2_player_wait1", player, 1);
      step(1);
      X_state[4] = 1'b1;
      check("t2_busy_wait2", busy, 1);
      check("t2_player_wait2", player, 1);
      step(1);
      check("t2_busy_after", busy, 0);
      check("t2_player_toggled", player, 0);
      btn[2] = 1'b0;
      step(12);

      // 3: place on an occupied tile
      X_state = 9'b000_010_000;
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0));
      tap(2);
      check("t3_player_kept", player, 0);
      check("t3_queue_drained", exp_q.size(), 0);

      // 4: board never updates -> timeout reject
      tap(0);
      check("t4_cursor", cursor, 6);
      exp_q.push_back(mk(1'b1, 4'd6, 1'b0));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0));
      tap(2);
      check("t4_player_kept", player, 0);
      check("t4_busy_idle", busy, 0);
      check("t4_queue_drained", exp_q.size(), 0);
      tap(0);
      check("t4_select_again", cursor, 7);

      // 5: bouncing next button, then held
      for (int i = 0; i < 10; i++) begin
         btn[0] = (i % 2 == 0);
         step(1);
      end
      btn[0] = 1'b1;
      step(6);
      check("t5_before_press", cursor, 7);
      step(1);
      check("t5_after_press", cursor, 8);
      step(10);
      check("t5_single_press", cursor, 8);
      btn[0] = 1'b0;
      step(10);
      btn[1:0] = 2'b11;
      step(10);
      btn[1:0] = 2'b00;
      step(10);
      check("t5_next_prev_same", cursor, 8);

      // 6: game over lock-out and new-game exit
      GameStatus = 3'd1;
      step(2);
      tap(2);
      tap(0);
      check("t6_done_cursor", cursor, 8);
      check("t6_done_busy", busy, 0);
      GameStatus = 3'd0;
      step(3);
      check("t6_still_done_player", player, 0);
      check("t6_still_done_cursor", cursor, 8);
      X_state = 9'd0;
      O_state = 9'd0;
      step(2);
      check("t6_newgame_player", player, 1);
      check("t6_newgame_cursor", cursor, 5);

      // 6b: reset while waiting for the board
      exp_q.push_back(mk(1'b1, 4'd5, 1'b1));
      btn[2] = 1'b1;
      wait_move();
      step(1);
      check("t6_in_wait_busy", busy, 1);
      rst = 1'b0;
      step(1);
      check_reset_outputs("t6_rst_in_wait");
      btn[2] = 1'b0;
      step(3);
      rst = 1'b1;
      step(20);
      check("t6_no_repulse_busy", busy, 0);
      check("final_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Upstream input stage for the tic-tac-toe game-state block.
- Turns raw pushbuttons into debounced press events and moves a tile cursor over tiles 1..9.
- Checks the target tile against the current board and issues a one-cycle move request with the tile and the player.
- Alternates the player once the board shows the move landed, and locks out input after a win or draw.

Parameters:
DB_CYCLES, 16, consecutive stable synchronized samples needed before a debounced button level changes
WAIT_TIMEOUT, 4, cycles to wait after a move request for the target tile to appear occupied

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
btn_next  in  1  raw button: advance cursor
btn_prev  in  1  raw button: retreat cursor
btn_place  in  1  raw button: place mark at cursor
X_state  in  9  board X occupancy; tile k = bit (9-k)
O_state  in  9  board O occupancy; same mapping
GameStatus  in  3  0 playing, 1/2 win, 3 draw, 4 invalid
move  out  1  one-cycle move request
player  out  1  1 = X, 0 = O; side to move
nextMove  out  4  tile 1..9 requested; held stable from ISSUE through WAIT
cursor  out  4  highlighted tile 1..9
busy  out  1  high in ISSUE and WAIT
reject  out  1  one-cycle pulse: refused or failed placement

Behaviour:
- Reset (rst==0 at a clk edge), applied from any state, mid-move included:
  - state SELECT, cursor=5, nextMove=0, player=1, move=0, busy=0, reject=0.
  - All sync flops, debounced levels and counters are cleared.
  - A move never re-pulses after reset.
- Per-button input conditioning:
  - 2-flop synchronizer, then a counter.
  - While the synchronized sample differs from the debounced level, the counter increments; otherwise it clears.
  - At DB_CYCLES the debounced level flips and the counter clears.
  - A press event is one cycle on the debounced 0->1 edge.
  - A button held through reset release yields a press DB_CYCLES+2 cycles after release.
- occ = X_state | O_state. tile_occ(k) = occ[9-k].
- FSM states: SELECT, ISSUE, WAIT, DONE.
- SELECT:
  - If GameStatus is 1, 2 or 3, go to DONE; this takes priority over all presses that cycle.
  - place press takes priority over next/prev; the cursor is unchanged that cycle.
    - tile_occ(cursor)=1: reject pulses for one cycle; stay in SELECT.
    - Otherwise: nextMove<=cursor; go to ISSUE.
  - next press only: cursor <= (cursor==9) ? 1 : cursor+1.
  - prev press only: cursor <= (cursor==1) ? 9 : cursor-1.
  - next and prev pressed in the same cycle: no change.
- ISSUE:
  - move=1 for exactly one cycle; busy=1.
  - nextMove and player are stable; the wait counter is cleared.
  - Go to WAIT.
- WAIT:
  - busy=1; presses are discarded, not queued.
  - tile_occ(nextMove)=1: player<=~player; go to SELECT.
  - Otherwise the counter increments. On reaching WAIT_TIMEOUT: reject pulses, player is unchanged, go to SELECT.
- DONE:
  - move=0, busy=0; all presses ignored, and no reject pulses.
  - Exit to SELECT with player=1 and cursor=5 when GameStatus==0 and occ==0 (external new game).
- Latency, settled press to move pulse: place event (cycle N) -> ISSUE with move=1 at N+1. A player toggle is visible the cycle after occupancy is seen.
- move is never high in two consecutive cycles.
- A new move issues only from SELECT.

Test Plan (DB_CYCLES=4, WAIT_TIMEOUT=4):
1. Reset, then 3 next presses, then 1 prev press -> cursor reads 6, 7, 8, then 7. From cursor 9, next -> 1; from cursor 1, prev -> 9.
2. Cursor=5, empty board, place press; model sets X_state bit4 two cycles after move -> move high one cycle with nextMove=5, player=1. player=0 the cycle after bit4 is seen. busy high exactly from ISSUE through WAIT exit.
3. X_state=9'b000_010_000, cursor=5, place -> reject one cycle, no move pulse, player unchanged.
4. Place on a free tile with the board never updating -> reject pulse after 4 WAIT cycles, player unchanged. SELECT is re-entered and accepts the next press.
5. Button bouncing 1,0,1,0 each cycle for 10 cycles, then held high -> exactly one press event, 6 cycles after the final rise. Next and prev pressed in the same cycle -> cursor unchanged.
6. Drive GameStatus=1 in SELECT -> DONE, and presses give no move and no reject. Then GameStatus=0 with an empty board -> SELECT, player=1, cursor=5. Separately, assert rst in WAIT -> all outputs at reset values on the next cycle.
